// File: rtl/mac_job_ctrl.sv
// mac_job_ctrl
// Job sequencer that sits in front of a non-pipelined MAC and owns all of
// its control pins. It accepts a job command (mode, length N), clears the
// MAC, configures the mode, streams N operand pairs through a valid/ready
// handshake, then reads the accumulated result and a sticky error flag.
// The result is held until the consumer takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   abort                 synchronous job abort (ignored in IDLE)
//   cmd_valid/cmd_ready   job command handshake (cmd_ready only in IDLE)
//   cmd_mode, cmd_len     job mode (1 = fp16, 0 = int8) and pair count N
//   op_valid/op_ready     operand pair handshake, op_a/op_b operands
//   res_valid/res_ready   result handshake, res_data/res_error payload
//   busy                  high in any state except IDLE
//   mac_*                 control/data pins driven into the MAC
//   mac_out, mac_error    MAC result and error flag

module mac_job_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_error,
  output logic             busy,
  output logic             mac_rst_n,
  output logic             mac_enable,
  output logic             mac_valid,
  output logic             mac_read,
  output logic             mac_cfg,
  output logic             mac_mode,
  output logic [15:0]      mac_in_a,
  output logic [15:0]      mac_in_b,
  input  logic [15:0]      mac_out,
  input  logic             mac_error
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CFG,
    STREAM,
    READ,
    RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             mode_q;
  logic             err_q;
  logic [15:0]      res_data_q;
  logic             res_error_q;

  logic accept;
  logic pair_fire;
  logic last_pair;

  assign accept    = (state == IDLE) && cmd_valid;
  // abort blocks the handshake in the same cycle, so no pair slips in
  assign pair_fire = (state == STREAM) && op_valid && !abort;
  // cnt counts completed pairs, so the last pair is the one seen at len_q-1;
  // cnt therefore tops out at len_q and never wraps even for the max length
  assign last_pair = (cnt == (len_q - LEN_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition outside IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = CLEAR;
      CLEAR:   state_next = CFG;
      CFG:     state_next = (len_q == '0) ? READ : STREAM;
      STREAM:  if (pair_fire && last_pair) state_next = READ;
      READ:    state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if ((state != IDLE) && abort) begin
      state_next = IDLE;
    end
  end

  // Output decode
  always_comb begin
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = (state != IDLE);
    mac_rst_n  = 1'b1;
    mac_enable = 1'b0;
    mac_valid  = 1'b0;
    mac_read   = 1'b0;
    mac_cfg    = 1'b0;
    mac_mode   = (state != IDLE) ? mode_q : 1'b0;
    mac_in_a   = 16'h0000;
    mac_in_b   = 16'h0000;
    case (state)
      IDLE:   cmd_ready = 1'b1;
      CLEAR:  mac_rst_n = 1'b0;
      CFG:    mac_cfg = 1'b1;
      STREAM: begin
        mac_enable = 1'b1;
        op_ready   = !abort;
        mac_valid  = op_valid && !abort;
        mac_in_a   = op_a;
        mac_in_b   = op_b;
      end
      READ: begin
        mac_enable = 1'b1;
        mac_read   = 1'b1;
      end
      RESP:   res_valid = 1'b1;
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign res_data  = res_data_q;
  assign res_error = res_error_q;

  // Job registers: command latch, pair counter, sticky error and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      res_data_q  <= 16'h0000;
      res_error_q <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= cmd_mode;
        len_q  <= cmd_len;
        cnt    <= '0;
        err_q  <= 1'b0;
      end
      if (pair_fire) begin
        cnt <= cnt + LEN_W'(1);
      end
      if ((state == STREAM) || (state == READ)) begin
        err_q <= err_q | mac_error;
      end
      if (state == READ) begin
        res_data_q  <= mac_out;
        res_error_q <= err_q | mac_error;
      end
    end
  end

endmodule

// File: tb/tb_mac_job_ctrl.sv
// tb_mac_job_ctrl
// Bench for mac_job_ctrl. A small behavioural MAC (int8 and fp16 through
// reals) answers the controller's pins. Jobs come from a table of records;
// the expected result is pushed into a queue when the command is driven and
// popped when res_valid appears. Hand-written sequences cover N = 0, abort
// and reset in the middle of a stream.

module tb_mac_job_ctrl;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             abort;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic             res_error;
  logic             busy;
  logic             mac_rst_n;
  logic             mac_enable;
  logic             mac_valid;
  logic             mac_read;
  logic             mac_cfg;
  logic             mac_mode;
  logic [15:0]      mac_in_a;
  logic [15:0]      mac_in_b;
  logic [15:0]      mac_out;
  logic             mac_error;

  mac_job_ctrl #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_len    (cmd_len),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_error  (res_error),
    .busy       (busy),
    .mac_rst_n  (mac_rst_n),
    .mac_enable (mac_enable),
    .mac_valid  (mac_valid),
    .mac_read   (mac_read),
    .mac_cfg    (mac_cfg),
    .mac_mode   (mac_mode),
    .mac_in_a   (mac_in_a),
    .mac_in_b   (mac_in_b),
    .mac_out    (mac_out),
    .mac_error  (mac_error)
  );

  always #5 clk = ~clk;

  // Free-running cycle count, used for latency measurements
  int cyc = 0;
  always @(posedge clk) cyc++;

  // fp16 <-> real helpers for the behavioural MAC
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
    else v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2fp(input real x);
    real v;
    int  e;
    logic s;
    logic [9:0] m;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 15;
    while (v >= 2.0 && e < 31) begin v = v / 2.0; e++; end
    while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
    if (v < 1.0) begin
      m = 10'($rtoi(v * 512.0));
      return {s, 5'd0, m};
    end
    m = 10'($rtoi((v - 1.0) * 1024.0));
    return {s, 5'(e), m};
  endfunction

  // Behavioural non-pipelined MAC
  logic        stub_mode;
  logic [15:0] acc_i;
  real         acc_r;
  logic signed [15:0] prod_i;

  always_comb prod_i = $signed(mac_in_a[7:0]) * $signed(mac_in_b[7:0]);

  always @(posedge clk) begin
    if (!mac_rst_n) begin
      acc_i     <= 16'h0000;
      acc_r     <= 0.0;
      stub_mode <= 1'b0;
    end else if (mac_cfg && !mac_enable) begin
      stub_mode <= mac_mode;
    end else if (mac_enable && mac_valid) begin
      if (stub_mode) acc_r <= acc_r + fp2r(mac_in_a) * fp2r(mac_in_b);
      else acc_i <= acc_i + prod_i;
    end
  end

  always_comb mac_out = stub_mode ? r2fp(acc_r) : acc_i;

  // Protocol monitors
  int valid_pulses = 0;
  int cfg_pulses   = 0;
  int cfg_bad      = 0;
  always @(posedge clk) begin
    if (mac_enable && mac_valid) valid_pulses++;
    if (mac_cfg) begin
      if (!mac_enable) cfg_pulses++;
      else cfg_bad++;
    end
  end

  // Checking bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct packed {
    logic             mode;
    logic [LEN_W-1:0] len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    bit               bubbles;
    int               err_at;
    logic [15:0]      exp_data;
    logic             exp_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   t_cmd;
  int   vp_start;
  int   cp_start;

  function automatic vec_t mk(input logic mode, input int len,
                              input logic [15:0] a0, input logic [15:0] b0,
                              input logic [15:0] a1, input logic [15:0] b1,
                              input logic [15:0] a2, input logic [15:0] b2,
                              input bit bubbles, input int err_at,
                              input logic [15:0] exp_data, input logic exp_err);
    vec_t v;
    v          = '0;
    v.mode     = mode;
    v.len      = LEN_W'(len);
    v.a[0]     = a0; v.b[0] = b0;
    v.a[1]     = a1; v.b[1] = b1;
    v.a[2]     = a2; v.b[2] = b2;
    v.bubbles  = bubbles;
    v.err_at   = err_at;
    v.exp_data = exp_data;
    v.exp_err  = exp_err;
    return v;
  endfunction

  // Drive one command and stream its pairs. abort_after >= 0 stops the job
  // after that many handshakes with abort (or an rst_n pulse if use_reset).
  task automatic applyStimulus(input vec_t v, input int abort_after, input bit use_reset);
    int k;
    int budget;
    int seen;
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = v.mode;
    cmd_len   = v.len;
    t_cmd     = cyc;
    vp_start  = valid_pulses;
    cp_start  = cfg_pulses;
    if (abort_after < 0) exp_q.push_back('{data: v.exp_data, err: v.exp_err});
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mode  = ~v.mode;
    cmd_len   = LEN_W'($urandom);
    check("busy_after_accept", {30'd0, busy, cmd_ready}, 32'b10);
    k      = 0;
    budget = 200;
    while (k < int'(v.len) && budget > 0) begin
      if (abort_after >= 0 && k == abort_after) break;
      op_valid  = v.bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      op_a      = v.a[k];
      op_b      = v.b[k];
      #1;
      mac_error = op_valid && op_ready && (k == v.err_at);
      if (op_valid && op_ready) k++;
      @(negedge clk);
      budget--;
    end
    op_valid  = 1'b0;
    mac_error = 1'b0;
    if (budget == 0) check("stream_timeout", 32'd0, 32'd1);
    if (abort_after >= 0) begin
      if (use_reset) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {29'd0, busy, mac_enable, mac_rst_n}, 32'b001);
        check("rst_mid_res_data", 32'(res_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        abort    = 1'b1;
        op_valid = 1'b1;
        op_a     = 16'h0009;
        op_b     = 16'h0009;
        #1;
        check("abort_op_ready_low", {30'd0, op_ready, mac_valid}, 32'b00);
        @(negedge clk);
        abort    = 1'b0;
        op_valid = 1'b0;
        check("abort_idle", {29'd0, busy, mac_enable, cmd_ready}, 32'b001);
      end
      seen = 0;
      repeat (5) begin
        if (res_valid) seen++;
        @(negedge clk);
      end
      check("no_result_after_stop", 32'(seen), 32'd0);
    end
  endtask

  // Wait for the result, compare it with the scoreboard, then release it
  task automatic checkOutput(input vec_t v, input bit check_latency);
    int   budget;
    exp_t e;
    budget = 100;
    while (!res_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!res_valid) begin
      check("res_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (check_latency) check("res_latency", 32'(cyc - t_cmd), 32'(4 + int'(v.len)));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("res_data", 32'(res_data), 32'(e.data));
    check("res_error", 32'(res_error), 32'(e.err));
    check("mac_valid_pulses", 32'(valid_pulses - vp_start), 32'(v.len));
    check("mac_cfg_pulses", 32'(cfg_pulses - cp_start), 32'd1);
    check("mac_cfg_while_enabled", 32'(cfg_bad), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_resp", {30'd0, busy, cmd_ready}, 32'b01);
  endtask

  vec_t vecs[6];
  vec_t v_zero;
  vec_t v_abort;

  initial begin
    int   saw_op;
    int   stable_bad;
    // Table: mode, N, pairs, bubbles, error pair, expected data/error
    vecs[0] = mk(1'b1, 2, 16'h3C00, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0, 1'b0, -1, 16'h4600, 1'b0);
    vecs[1] = mk(1'b1, 1, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, -1, 16'h3C00, 1'b0);
    vecs[2] = mk(1'b1, 1, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, -1, 16'h3C00, 1'b0);
    vecs[3] = mk(1'b0, 3, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0001, 16'h0001, 1'b1, -1, 16'h002B, 1'b0);
    vecs[4] = mk(1'b0, 2, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0, 16'h0, 1'b0, 1, 16'h001A, 1'b1);
    vecs[5] = mk(1'b0, 1, 16'h0007, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, -1, 16'h0031, 1'b0);
    v_zero  = mk(1'b0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, -1, 16'h0000, 1'b0);
    v_abort = mk(1'b0, 4, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 1'b0, -1, 16'h0, 1'b0);

    rst_n     = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_len   = '0;
    op_valid  = 1'b0;
    op_a      = 16'h0;
    op_b      = 16'h0;
    res_ready = 1'b0;
    mac_error = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs",
          {21'd0, cmd_ready, busy, res_valid, res_error, mac_rst_n, mac_enable,
           mac_valid, mac_read, mac_cfg, mac_mode, op_ready},
          {21'd0, 11'b1_0_0_0_1_0_0_0_0_0_0});
    check("reset_res_data", 32'(res_data), 32'd0);
    check("reset_mac_operands", {mac_in_a, mac_in_b}, 32'd0);
    rst_n = 1'b1;

    // abort in IDLE must not start anything
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_idle", {30'd0, busy, cmd_ready}, 32'b01);

    // Table-driven jobs; latency checked only where pairs are back-to-back
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], -1, 1'b0);
      checkOutput(vecs[i], !vecs[i].bubbles);
    end

    // N = 0: straight to READ, then hold the response for 5 cycles
    applyStimulus(v_zero, -1, 1'b0);
    saw_op = 0;
    while (cyc - t_cmd < 3) begin
      if (op_ready) saw_op++;
      @(negedge clk);
    end
    check("n0_read_cycle", {29'd0, mac_read, mac_enable, mac_valid}, 32'b110);
    check("n0_no_op_ready", 32'(saw_op), 32'd0);
    @(negedge clk);
    check("n0_res_valid_at_t4", 32'(res_valid), 32'd1);
    stable_bad = 0;
    repeat (5) begin
      if (!res_valid || res_data !== 16'h0000 || cmd_ready || !busy) stable_bad++;
      @(negedge clk);
    end
    check("n0_resp_hold_stable", 32'(stable_bad), 32'd0);
    checkOutput(v_zero, 1'b0);

    // abort after 1 of 4 pairs, then a normal job
    applyStimulus(v_abort, 1, 1'b0);
    applyStimulus(vecs[5], -1, 1'b0);
    checkOutput(vecs[5], 1'b1);

    // rst_n pulse after 1 of 4 pairs, then a normal fp16 job
    applyStimulus(v_abort, 1, 1'b1);
    applyStimulus(vecs[0], -1, 1'b0);
    checkOutput(vecs[0], 1'b1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
